// File: rtl/ternary_prog_loader.sv
// ternary_prog_loader
//   Byte-stream loader for the ternary CPU instruction memory. Parses frames
//   of the form  A5, LEN, LEN x {LO, HI}, CHK  and writes each 9-bit word
//   {HI[0], LO} to consecutive addresses starting at 0. CHK is the XOR of LEN
//   and every LO/HI byte. While a frame is in flight the CPU is held
//   (cpu_run=0). It is released only when the checksum of the frame matches.
//
// Ports
//   clk, rst_n      system clock, asynchronous active-low reset
//   rx_data/valid   upstream byte source
//   rx_ready        byte accepted when rx_valid && rx_ready at posedge clk
//   prog_mode       high from magic accept until the frame ends (DONE/ERROR)
//   prog_addr/data  instruction-memory write address / word
//   prog_we         one-cycle write strobe
//   cpu_run         CPU execution permit
//   load_done       sticky: last frame loaded with a good checksum
//   load_error      sticky: last frame aborted (length/format/checksum/timeout)
//   words_loaded    words written in the current or last frame
module ternary_prog_loader #(
  parameter int IMEM_DEPTH     = 243,
  parameter int PROG_DATA_W    = 9,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [7:0]             rx_data,
  input  logic                   rx_valid,
  output logic                   rx_ready,
  output logic                   prog_mode,
  output logic [7:0]             prog_addr,
  output logic [PROG_DATA_W-1:0] prog_data,
  output logic                   prog_we,
  output logic                   cpu_run,
  output logic                   load_done,
  output logic                   load_error,
  output logic [7:0]             words_loaded
);

  localparam logic [7:0] MAGIC = 8'hA5;
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN, S_DATA_LO, S_DATA_HI, S_WRITE, S_CHECK, S_DONE, S_ERROR
  } state_t;

  state_t           r_state,      w_state;
  logic             r_prog_mode,  w_prog_mode;
  logic [7:0]       r_prog_addr,  w_prog_addr;
  logic [8:0]       r_prog_data,  w_prog_data;
  logic             r_cpu_run,    w_cpu_run;
  logic             r_load_done,  w_load_done;
  logic             r_load_error, w_load_error;
  logic [7:0]       r_words,      w_words;
  logic [7:0]       r_len,        w_len;
  logic [7:0]       r_chk,        w_chk;
  logic [TMO_W-1:0] r_tmo,        w_tmo;

  logic w_rx_ready;
  logic w_acc;
  logic w_abort;
  logic w_counting;

  // Only the write cycle stalls the byte source; both strobes decode straight
  // from the state register so an async reset kills prog_we at once.
  assign w_rx_ready = (r_state != S_WRITE);
  assign w_acc      = rx_valid & w_rx_ready;
  assign w_counting = (r_state == S_LEN) || (r_state == S_DATA_LO) ||
                      (r_state == S_DATA_HI) || (r_state == S_CHECK);

  always_comb begin
    w_state      = r_state;
    w_prog_mode  = r_prog_mode;
    w_prog_addr  = r_prog_addr;
    w_prog_data  = r_prog_data;
    w_cpu_run    = r_cpu_run;
    w_load_done  = r_load_done;
    w_load_error = r_load_error;
    w_words      = r_words;
    w_len        = r_len;
    w_chk        = r_chk;
    w_tmo        = r_tmo;
    w_abort      = 1'b0;

    case (r_state)
      S_IDLE, S_DONE, S_ERROR: begin
        w_tmo = '0;
        // Non-magic bytes are consumed and dropped.
        if (w_acc && rx_data == MAGIC) begin
          w_state      = S_LEN;
          w_load_done  = 1'b0;
          w_load_error = 1'b0;
          w_words      = 8'd0;
          w_prog_addr  = 8'd0;
          w_prog_mode  = 1'b1;
          w_cpu_run    = 1'b0;
        end
      end
      S_LEN: begin
        if (w_acc) begin
          // Bounding LEN here is what keeps prog_addr inside the memory.
          if (rx_data == 8'd0 || int'(rx_data) > IMEM_DEPTH) begin
            w_abort = 1'b1;
          end else begin
            w_len   = rx_data;
            w_chk   = rx_data;
            w_state = S_DATA_LO;
          end
        end
      end
      S_DATA_LO: begin
        if (w_acc) begin
          w_prog_data[7:0] = rx_data;
          w_chk            = r_chk ^ rx_data;
          w_state          = S_DATA_HI;
        end
      end
      S_DATA_HI: begin
        if (w_acc) begin
          if (rx_data[7:1] != 7'd0) begin
            w_abort = 1'b1;
          end else begin
            w_prog_data[8] = rx_data[0];
            w_chk          = r_chk ^ rx_data;
            w_state        = S_WRITE;
          end
        end
      end
      S_WRITE: begin
        w_prog_addr = r_prog_addr + 8'd1;
        w_words     = r_words + 8'd1;
        w_state     = ((r_words + 8'd1) == r_len) ? S_CHECK : S_DATA_LO;
      end
      S_CHECK: begin
        if (w_acc) begin
          if (rx_data == r_chk) begin
            w_state     = S_DONE;
            w_load_done = 1'b1;
            w_cpu_run   = 1'b1;
            w_prog_mode = 1'b0;
          end else begin
            w_abort = 1'b1;
          end
        end
      end
      default: w_state = S_IDLE;
    endcase

    // Inter-byte watchdog: restarts on every accepted byte, holds in WRITE.
    if (w_counting) begin
      if (w_acc) begin
        w_tmo = '0;
      end else if (r_tmo == TMO_MAX) begin
        w_abort = 1'b1;
      end else begin
        w_tmo = r_tmo + 1'b1;
      end
    end

    // Common abort path; words already written are left in place.
    if (w_abort) begin
      w_state      = S_ERROR;
      w_load_error = 1'b1;
      w_load_done  = 1'b0;
      w_prog_mode  = 1'b0;
      w_cpu_run    = 1'b0;
      w_tmo        = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_prog_mode  <= 1'b0;
      r_prog_addr  <= 8'd0;
      r_prog_data  <= 9'd0;
      r_cpu_run    <= 1'b1;
      r_load_done  <= 1'b0;
      r_load_error <= 1'b0;
      r_words      <= 8'd0;
      r_len        <= 8'd0;
      r_chk        <= 8'd0;
      r_tmo        <= '0;
    end else begin
      r_state      <= w_state;
      r_prog_mode  <= w_prog_mode;
      r_prog_addr  <= w_prog_addr;
      r_prog_data  <= w_prog_data;
      r_cpu_run    <= w_cpu_run;
      r_load_done  <= w_load_done;
      r_load_error <= w_load_error;
      r_words      <= w_words;
      r_len        <= w_len;
      r_chk        <= w_chk;
      r_tmo        <= w_tmo;
    end
  end

  assign rx_ready     = w_rx_ready;
  assign prog_we      = (r_state == S_WRITE);
  assign prog_mode    = r_prog_mode;
  assign prog_addr    = r_prog_addr;
  assign prog_data    = PROG_DATA_W'(r_prog_data);
  assign cpu_run      = r_cpu_run;
  assign load_done    = r_load_done;
  assign load_error   = r_load_error;
  assign words_loaded = r_words;

endmodule

// File: tb/tb_ternary_prog_loader.sv
// Directed testbench for ternary_prog_loader (TIMEOUT_CYCLES overridden to 16).
module tb_ternary_prog_loader;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] rx_data = 8'd0;
  logic       rx_valid = 1'b0;
  logic       rx_ready, prog_mode, prog_we, cpu_run, load_done, load_error;
  logic [7:0] prog_addr, words_loaded;
  logic [8:0] prog_data;

  int checks = 0;
  int fails  = 0;

  logic [7:0] fb[$];
  logic [7:0] wa[$];
  logic [8:0] wd[$];

  ternary_prog_loader #(.IMEM_DEPTH(243), .PROG_DATA_W(9), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .prog_mode(prog_mode), .prog_addr(prog_addr),
    .prog_data(prog_data), .prog_we(prog_we), .cpu_run(cpu_run),
    .load_done(load_done), .load_error(load_error), .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  // Write capture plus per-cycle invariants.
  always @(negedge clk) begin
    if (prog_we) begin
      wa.push_back(prog_addr);
      wd.push_back(prog_data);
      checks++;
      if (prog_addr > 8'd242) begin
        fails++;
        $display("FAIL addr_range got=%0d max=242", prog_addr);
      end
    end
    checks++;
    if (rx_ready !== ~prog_we) begin
      fails++;
      $display("FAIL ready_vs_we rx_ready=%b prog_we=%b", rx_ready, prog_we);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Streams fb with rx_valid held high; ends #1 after the last byte's edge.
  task automatic stream();
    int i = 0;
    int g = 0;
    logic rr;
    rx_valid = 1'b1;
    while (i < fb.size() && g < 4 * fb.size() + 20) begin
      rx_data = fb[i];
      rr = rx_ready;
      @(posedge clk); #1;
      if (rr) i++;
      g++;
    end
    rx_valid = 1'b0;
    checks++;
    if (i != fb.size()) begin
      fails++;
      $display("FAIL stream_stall sent=%0d need=%0d", i, fb.size());
    end
  endtask

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin @(posedge clk); #1; end
  endtask

  task automatic clr_wr();
    wa.delete(); wd.delete();
  endtask

  task automatic test_reset();
    checks++;
    if ({rx_ready, prog_mode, prog_we, cpu_run, load_done, load_error} !== 6'b100100) begin
      fails++;
      $display("FAIL reset_flags got=%b exp=100100",
               {rx_ready, prog_mode, prog_we, cpu_run, load_done, load_error});
    end
    checks++;
    if ({prog_addr, prog_data, words_loaded} !== 25'd0) begin
      fails++;
      $display("FAIL reset_values addr=%h data=%h words=%h exp=0", prog_addr, prog_data, words_loaded);
    end
  endtask

  task automatic test_noise();
    clr_wr();
    fb = '{8'h00, 8'hFF, 8'h5A};
    stream();
    tick(2);
    checks++;
    if ({prog_mode, cpu_run, load_done, load_error, words_loaded} !== {4'b0100, 8'd0} || wa.size() != 0) begin
      fails++;
      $display("FAIL noise_idle mode=%b run=%b done=%b err=%b words=%0d writes=%0d exp 0,1,0,0,0,0",
               prog_mode, cpu_run, load_done, load_error, words_loaded, wa.size());
    end
  endtask

  task automatic test_good_load();
    clr_wr();
    fb = '{8'hA5, 8'h02, 8'h12, 8'h01, 8'h34, 8'h00, 8'h25};
    stream();
    checks++;
    if (wa.size() != 2) begin
      fails++;
      $display("FAIL good_write_count got=%0d exp=2", wa.size());
    end else begin
      checks++;
      if (wa[0] !== 8'd0 || wd[0] !== 9'h112 || wa[1] !== 8'd1 || wd[1] !== 9'h034) begin
        fails++;
        $display("FAIL good_writes got %h:%h %h:%h exp 00:112 01:034", wa[0], wd[0], wa[1], wd[1]);
      end
    end
    checks++;
    if ({load_done, load_error, cpu_run, prog_mode} !== 4'b1010 || words_loaded !== 8'd2) begin
      fails++;
      $display("FAIL good_status done=%b err=%b run=%b mode=%b words=%0d exp 1,0,1,0,2",
               load_done, load_error, cpu_run, prog_mode, words_loaded);
    end
    // Noise while DONE must not disturb the sticky result.
    fb = '{8'h00, 8'hFF, 8'h5A};
    stream();
    checks++;
    if ({load_done, cpu_run, prog_mode} !== 3'b110 || words_loaded !== 8'd2) begin
      fails++;
      $display("FAIL noise_done done=%b run=%b mode=%b words=%0d exp 1,1,0,2",
               load_done, cpu_run, prog_mode, words_loaded);
    end
  endtask

  task automatic test_latency();
    clr_wr();
    fb = '{8'hA5, 8'h01, 8'h05, 8'h00};
    stream();
    checks++;
    if (prog_we !== 1'b1 || rx_ready !== 1'b0 || prog_addr !== 8'd0 || prog_data !== 9'h005
        || prog_mode !== 1'b1 || cpu_run !== 1'b0) begin
      fails++;
      $display("FAIL write_cycle we=%b rdy=%b addr=%h data=%h mode=%b run=%b exp 1,0,00,005,1,0",
               prog_we, rx_ready, prog_addr, prog_data, prog_mode, cpu_run);
    end
    tick(1);
    checks++;
    if (prog_we !== 1'b0 || prog_addr !== 8'd1 || words_loaded !== 8'd1) begin
      fails++;
      $display("FAIL after_write we=%b addr=%0d words=%0d exp 0,1,1", prog_we, prog_addr, words_loaded);
    end
    fb = '{8'h04};
    stream();
    checks++;
    if (load_done !== 1'b1 || cpu_run !== 1'b1 || wa.size() != 1) begin
      fails++;
      $display("FAIL latency_done done=%b run=%b writes=%0d exp 1,1,1", load_done, cpu_run, wa.size());
    end
  endtask

  task automatic test_bad_checksum();
    clr_wr();
    fb = '{8'hA5, 8'h01, 8'h07, 8'h00, 8'h00};
    stream();
    checks++;
    if (wa.size() != 1 || wa[0] !== 8'd0 || wd[0] !== 9'h007) begin
      fails++;
      $display("FAIL badchk_write writes=%0d exp one write 00:007", wa.size());
    end
    checks++;
    if ({load_error, load_done, cpu_run, prog_mode} !== 4'b1000 || words_loaded !== 8'd1) begin
      fails++;
      $display("FAIL badchk_status err=%b done=%b run=%b mode=%b words=%0d exp 1,0,0,0,1",
               load_error, load_done, cpu_run, prog_mode, words_loaded);
    end
    clr_wr();
    fb = '{8'hA5, 8'h02, 8'h12, 8'h01, 8'h34, 8'h00, 8'h25};
    stream();
    checks++;
    if ({load_done, load_error, cpu_run} !== 3'b101 || wa.size() != 2) begin
      fails++;
      $display("FAIL recover done=%b err=%b run=%b writes=%0d exp 1,0,1,2",
               load_done, load_error, cpu_run, wa.size());
    end
  endtask

  task automatic test_format();
    clr_wr();
    fb = '{8'hA5, 8'h00};
    stream();
    checks++;
    if ({load_error, load_done, prog_mode, cpu_run} !== 4'b1000 || wa.size() != 0) begin
      fails++;
      $display("FAIL len_zero err=%b done=%b mode=%b run=%b writes=%0d exp 1,0,0,0,0",
               load_error, load_done, prog_mode, cpu_run, wa.size());
    end
    fb = '{8'hA5, 8'hF4};
    stream();
    checks++;
    if ({load_error, prog_mode} !== 2'b10 || wa.size() != 0) begin
      fails++;
      $display("FAIL len_244 err=%b mode=%b writes=%0d exp 1,0,0", load_error, prog_mode, wa.size());
    end
    fb = '{8'hA5, 8'h01, 8'h05, 8'h02};
    stream();
    tick(2);
    checks++;
    if ({load_error, prog_mode} !== 2'b10 || wa.size() != 0 || words_loaded !== 8'd0) begin
      fails++;
      $display("FAIL hi_format err=%b mode=%b writes=%0d words=%0d exp 1,0,0,0",
               load_error, prog_mode, wa.size(), words_loaded);
    end
  endtask

  // Maximum frame (243 words); A5 appears as data and must not resync.
  task automatic test_full_depth();
    logic [7:0] c;
    int bad = 0;
    clr_wr();
    fb.delete();
    fb.push_back(8'hA5);
    fb.push_back(8'd243);
    c = 8'd243;
    for (int i = 0; i < 243; i++) begin
      fb.push_back(8'(i + 8'h5B));
      fb.push_back({7'd0, i[0]});
      c = c ^ 8'(i + 8'h5B) ^ {7'd0, i[0]};
    end
    fb.push_back(c);
    stream();
    checks++;
    if (load_done !== 1'b1 || load_error !== 1'b0 || words_loaded !== 8'd243 || wa.size() != 243) begin
      fails++;
      $display("FAIL full_depth done=%b err=%b words=%0d writes=%0d exp 1,0,243,243",
               load_done, load_error, words_loaded, wa.size());
    end else begin
      for (int i = 0; i < 243; i++)
        if (wa[i] !== 8'(i) || wd[i] !== {i[0], 8'(i + 8'h5B)}) bad++;
      checks++;
      if (bad != 0 || wa[242] !== 8'd242) begin
        fails++;
        $display("FAIL full_depth_data bad_words=%0d last_addr=%0d exp 0,242", bad, wa[242]);
      end
    end
  endtask

  task automatic test_back_to_back();
    clr_wr();
    fb = '{8'hA5, 8'h03, 8'hA5, 8'h01, 8'h00, 8'h00, 8'hFF, 8'h01, 8'h59};
    stream();
    checks++;
    if (wa.size() != 3 || load_done !== 1'b1) begin
      fails++;
      $display("FAIL b2b_count writes=%0d done=%b exp 3,1", wa.size(), load_done);
    end else begin
      checks++;
      if (wd[0] !== 9'h1A5 || wd[1] !== 9'h000 || wd[2] !== 9'h1FF || wa[2] !== 8'd2) begin
        fails++;
        $display("FAIL b2b_data got %h %h %h@%0d exp 1a5 000 1ff@2", wd[0], wd[1], wd[2], wa[2]);
      end
    end
  endtask

  task automatic test_timeout();
    int early = 0;
    clr_wr();
    fb = '{8'hA5, 8'h03};
    stream();
    for (int k = 0; k < 15; k++) begin
      tick(1);
      if (load_error !== 1'b0 || prog_mode !== 1'b1) early++;
    end
    checks++;
    if (early != 0) begin
      fails++;
      $display("FAIL timeout_early early_cycles=%0d exp 0", early);
    end
    tick(1);
    checks++;
    if ({load_error, prog_mode, cpu_run, load_done} !== 4'b1000) begin
      fails++;
      $display("FAIL timeout err=%b mode=%b run=%b done=%b exp 1,0,0,0",
               load_error, prog_mode, cpu_run, load_done);
    end
  endtask

  task automatic test_reset_mid();
    clr_wr();
    // Reset while the first HI byte is being presented, before its write.
    fb = '{8'hA5, 8'h02, 8'h12};
    stream();
    rx_data = 8'h01; rx_valid = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({rx_ready, prog_mode, prog_we, cpu_run, load_done, load_error} !== 6'b100100
        || {prog_addr, prog_data, words_loaded} !== 25'd0) begin
      fails++;
      $display("FAIL reset_mid flags=%b addr=%h data=%h words=%h exp 100100,0,0,0",
               {rx_ready, prog_mode, prog_we, cpu_run, load_done, load_error}, prog_addr, prog_data, words_loaded);
    end
    rx_valid = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(3);
    checks++;
    if (wa.size() != 0 || prog_mode !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid_glitch writes=%0d mode=%b exp 0,0", wa.size(), prog_mode);
    end
    // Reset asserted during the write cycle drops prog_we asynchronously.
    fb = '{8'hA5, 8'h01, 8'h05, 8'h00};
    stream();
    rst_n = 1'b0;
    #1;
    checks++;
    if (prog_we !== 1'b0 || cpu_run !== 1'b1 || prog_addr !== 8'd0) begin
      fails++;
      $display("FAIL reset_in_write we=%b run=%b addr=%0d exp 0,1,0", prog_we, cpu_run, prog_addr);
    end
    tick(2);
    rst_n = 1'b1;
    tick(1);
    clr_wr();
    fb = '{8'hA5, 8'h02, 8'h12, 8'h01, 8'h34, 8'h00, 8'h25};
    stream();
    checks++;
    if (load_done !== 1'b1 || wa.size() != 2 || words_loaded !== 8'd2) begin
      fails++;
      $display("FAIL reset_reload done=%b writes=%0d words=%0d exp 1,2,2", load_done, wa.size(), words_loaded);
    end
  endtask

  initial begin
    #12 rst_n = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_noise();
    test_good_load();
    test_latency();
    test_bad_checksum();
    test_format();
    test_back_to_back();
    test_full_depth();
    test_timeout();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

// File: doc/ternary_prog_loader.md
Name: ternary_prog_loader

Overview:
Byte-stream program loader that drives the CPU system's instruction-memory programming port (prog_mode/prog_addr/prog_data/prog_we). It parses framed bytes from an upstream byte source (UART RX or host FIFO), assembles 9-bit instruction words, writes them sequentially from address 0, and validates each frame with a checksum. It also gates CPU execution: the CPU is held while a frame is in progress and released only after a good load. It sits between the board byte source and ternary_cpu_system inside the FPGA top.

Parameters:
IMEM_DEPTH, 243, number of instruction words; frames longer than this are rejected
PROG_DATA_W, 9, instruction word width on prog_data
TIMEOUT_CYCLES, 1000000, maximum idle clocks between bytes inside a frame before abort

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
rx_data  in  8  incoming byte
rx_valid  in  1  rx_data valid
rx_ready  out  1  loader accepts byte; transfer occurs when rx_valid && rx_ready at posedge clk
prog_mode  out  1  CPU programming mode; high from magic accept until frame end
prog_addr  out  8  instruction write address
prog_data  out  PROG_DATA_W  instruction write data
prog_we  out  1  one-cycle write strobe
cpu_run  out  1  1 = CPU permitted to execute (the top ANDs it into CPU reset)
load_done  out  1  sticky: last frame loaded and checksum matched
load_error  out  1  sticky: last frame aborted (length, format, checksum or timeout)
words_loaded  out  8  words written in the current or last frame

Behaviour:
- Reset values: rx_ready=1, prog_mode=0, prog_addr=0, prog_data=0, prog_we=0, cpu_run=1, load_done=0, load_error=0, words_loaded=0, state=IDLE.
- Frame format: 0xA5 (magic), LEN, then LEN pairs {LO, HI}, then CHK. word = {HI[0], LO}. CHK = XOR of LEN and all LO/HI bytes.
- States: IDLE, LEN, DATA_LO, DATA_HI, WRITE, CHECK, DONE, ERROR.
- IDLE/DONE/ERROR: rx_ready=1. An accepted 0xA5 goes to LEN and, on that edge, clears load_done, load_error, words_loaded and prog_addr; sets prog_mode=1 and cpu_run=0. Other bytes are dropped and cause no state change.
- LEN: accept a byte. LEN==0 or LEN>IMEM_DEPTH goes to ERROR. Otherwise latch the word count, seed the checksum with LEN, and go to DATA_LO.
- DATA_LO: accept LO into prog_data[7:0] and go to DATA_HI.
- DATA_HI: if HI[7:1]!=0, go to ERROR with no write. Otherwise set prog_data[8]=HI[0] and go to WRITE.
- WRITE: lasts exactly one cycle. rx_ready=0 and prog_we=1, with prog_addr/prog_data stable. At the end of the cycle, prog_addr and words_loaded each increment by 1. Next state is DATA_LO if words remain, else CHECK. Latency: hi byte accepted at edge k gives prog_we high during the cycle following edge k, for exactly one cycle.
- CHECK: accept CHK. On match go to DONE, setting load_done=1 and cpu_run=1. On mismatch go to ERROR.
- Entering ERROR from any state sets load_error=1, leaves cpu_run=0, and does not roll back words already written.
- prog_mode drops to 0 on the same edge that enters DONE or ERROR.
- rx_ready=0 only in WRITE. It is 1 in all other states.
- Timeout: the counter clears on every accepted byte and in IDLE/DONE/ERROR. It counts while in LEN, DATA_LO, DATA_HI or CHECK. When it reaches TIMEOUT_CYCLES-1 the loader enters ERROR.
- 0xA5 inside a frame is ordinary data, not a resync.
- Reset mid-frame (rst_n low, any cycle): all outputs return to reset values immediately and asynchronously. prog_we drops with no glitch write after release, and cpu_run returns to 1.
- prog_addr never exceeds IMEM_DEPTH-1 during prog_we. This follows from the LEN check, and the bench must confirm it.

Test Plan:
- Good load: A5 02 12 01 34 00 25 -> two single-cycle prog_we pulses: addr0 data 0x112, then addr1 data 0x034. load_done=1, load_error=0, words_loaded=2, cpu_run back to 1, prog_mode=0.
- Bad checksum: A5 01 07 00 00 -> one write (addr0 data 0x007), then load_error=1, load_done=0, cpu_run=0. A following good frame recovers with load_done=1.
- Format errors: LEN=0x00 -> ERROR with no write. LEN=0xF4 (244) -> ERROR. HI=0x02 -> ERROR with no write for that word.
- Noise and backpressure: bytes 00 FF 5A in IDLE -> ignored, no state change. rx_valid held high through the whole frame -> rx_ready low only in WRITE cycles, no byte lost or duplicated.
- Timeout: with TIMEOUT_CYCLES=16, send A5 03 then stall -> 16 cycles later load_error=1, prog_mode=0.
- Reset mid-frame: assert rst_n low after the first HI byte, before WRITE -> no prog_we, all outputs at reset values. A full frame after release loads normally.
